rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one N-bit output channel among M requesters; it owns the select of the wide input mux.
- Each requester has a valid/ready handshake. The winner's data is captured into a single output register with valid/ready handshake toward the consumer.
- Sits in front of shared datapath resources (shared bus, shared register-file write port) where several sources compete for one mux output.

---
 rtl/rr_mux_arbiter.sv | 71 +++++++
 tb/tb_rr_mux_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that owns the select of a wide input mux and registers the winner
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester valid (M bits)
//   req_data   requester i data at [i*N +: N]
//   req_ready  one-hot (or zero) grant, combinational
//   out_valid  output register holds a word
//   out_data   registered winner data
//   out_src    registered index of the winning requester
//   out_ready  consumer accepts out_data when out_valid & out_ready
module rr_mux_arbiter #(
    parameter int N = 32,
    parameter int M = 8,
    localparam int SW = (M > 1) ? $clog2(M) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req_valid,
    input  logic [M*N-1:0] req_data,
    output logic [M-1:0]   req_ready,
    output logic           out_valid,
    output logic [N-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    input  logic           out_ready
);
    logic [SW-1:0]         ptr;
    logic [SW-1:0]         win;
    logic                  found;
    logic                  load;
    logic [(1<<SW)-1:0]    valid_pad;
    int                    idx;

    // Scan ptr, ptr+1, ... with an explicit wrap at M so non-power-of-2 M never aliases.
    // The padded copy keeps every index in range of a full SW-bit select.
    always_comb begin
        valid_pad = '0;
        valid_pad[M-1:0] = req_valid;
        found = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 0; k < M; k++) begin
            idx = int'(ptr) + k;
            idx = (idx >= M) ? idx - M : idx;
            if (!found && valid_pad[idx[SW-1:0]]) begin
                found = 1'b1;
                win = idx[SW-1:0];
            end
        end
    end

    assign load = ~out_valid | out_ready;
    // Grants are held low while in reset so nothing appears accepted that will not be loaded.
    assign req_ready = (load && found && !rst) ? M'(1) << win : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_src <= '0;
            ptr <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= req_data[int'(win)*N +: N];
                out_src <= win;
                ptr <= (int'(win) == M - 1) ? '0 : win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench for rr_mux_arbiter (M=8 and M=5 instances)
module tb_rr_mux_arbiter;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]   req_valid, req_ready;
    logic [8*N-1:0] req_data;
    logic         out_valid, out_ready;
    logic [N-1:0] out_data;
    logic [2:0]   out_src;

    logic [4:0]   req_valid5, req_ready5;
    logic [5*N-1:0] req_data5;
    logic         out_valid5, out_ready5;
    logic [N-1:0] out_data5;
    logic [2:0]   out_src5;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(N), .M(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
    );

    rr_mux_arbiter #(.N(N), .M(5)) dut5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid5), .req_data(req_data5), .req_ready(req_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_src(out_src5), .out_ready(out_ready5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        req_valid5 = '0;
        req_data5 = '0;
        out_ready5 = 1'b0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_src", 64'(out_src), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        tick;
        tick;
        #2 rst = 1'b0;

        // single request from requester 3
        req_data[3*N +: N] = 32'd16;
        req_valid = 8'h08;
        out_ready = 1'b1;
        #1 check("single_grant", 64'(req_ready), 64'h08);
        tick;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'd16);
        check("single_src", 64'(out_src), 64'd3);
        req_valid = '0;
        tick;
        check("single_drain", 64'(out_valid), 64'd0);

        // async reset while FULL, pointer was 1 before reset
        req_data[0 +: N] = 32'd7;
        req_valid = 8'h01;
        tick;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_data", 64'(out_data), 64'd7);
        req_valid = '0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        req_valid = 8'hFF;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_src", 64'(out_src), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) req_data[i*N +: N] = 32'((i + 1) * (i + 1));
        out_ready = 1'b1;
        #1 check("post_rst_grant", 64'(req_ready), 64'h01);

        // full contention: 0..7,0 with no bubbles
        for (int k = 0; k < 9; k++) begin
            tick;
            check("cont_valid", 64'(out_valid), 64'd1);
            check("cont_src", 64'(out_src), 64'(k % 8));
            check("cont_data", 64'(out_data), 64'(((k % 8) + 1) * ((k % 8) + 1)));
            check("cont_grant", 64'(req_ready), 64'(8'd1 << ((k + 1) % 8)));
        end

        // backpressure after src 2
        tick;
        check("bp_src1", 64'(out_src), 64'd1);
        tick;
        check("bp_src2", 64'(out_src), 64'd2);
        out_ready = 1'b0;
        #1 check("bp_ready0", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'd9);
            check("bp_hold_src", 64'(out_src), 64'd2);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1 check("bp_release_grant", 64'(req_ready), 64'h08);
        tick;
        check("bp_next_src", 64'(out_src), 64'd3);
        check("bp_next_data", 64'(out_data), 64'd16);

        // wrap-around from ptr 6
        tick;
        check("wrap_src4", 64'(out_src), 64'd4);
        tick;
        check("wrap_src5", 64'(out_src), 64'd5);
        req_valid = 8'h82;
        #1 check("wrap_grant7", 64'(req_ready), 64'h80);
        tick;
        check("wrap_src7", 64'(out_src), 64'd7);
        check("wrap_data7", 64'(out_data), 64'd64);
        check("wrap_grant1", 64'(req_ready), 64'h02);
        tick;
        check("wrap_src1", 64'(out_src), 64'd1);
        check("wrap_data1", 64'(out_data), 64'd4);
        req_valid = 8'h07;
        #1 check("wrap_ptr2", 64'(req_ready), 64'h04);
        req_valid = '0;

        // non-power-of-2 M=5
        for (int i = 0; i < 5; i++) req_data5[i*N +: N] = 32'(100 + i);
        req_valid5 = 5'h1F;
        out_ready5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            check("m5_valid", 64'(out_valid5), 64'd1);
            check("m5_src", 64'(out_src5), 64'(k % 5));
            check("m5_data", 64'(out_data5), 64'(100 + k % 5));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
